// File: rtl/single_write_multi_read_lutram.sv
// Single-write, multi-read LUT RAM with a zero-clearing sweep after reset.
// Define LUTRAM_WRITE_FORWARD_EN for write-first collisions; read-first otherwise.
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module single_write_multi_read_lutram #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int NUM_READ_PORT             = 2,
    parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / `BYTE_LEN_IN_BITS
) (
    input  logic                                               clk_in,
    input  logic                                               reset_in,
    output logic                                               init_done_out,
    input  logic [WRITE_MASK_LEN-1:0]                          write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                   write_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]               write_entry_in,
    input  logic [NUM_READ_PORT-1:0]                           read_en_in,
    input  logic [NUM_READ_PORT*SET_PTR_WIDTH_IN_BITS-1:0]     read_set_addr_in,
    output logic [NUM_READ_PORT*SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out,
    output logic [NUM_READ_PORT-1:0]                           read_valid_out
);

    localparam int BL = `BYTE_LEN_IN_BITS;
    localparam int W  = SINGLE_ENTRY_SIZE_IN_BITS;
    localparam int AW = SET_PTR_WIDTH_IN_BITS;
    localparam int NP = NUM_READ_PORT;
    localparam logic [AW-1:0] LAST_SET = AW'(NUM_SET - 1);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t          state;
    logic [AW-1:0]   sweep_ptr;
    logic [W-1:0]    mem [NUM_SET];
    logic [AW-1:0]   raddr [NP];
    logic [W-1:0]    read_data [NP];
    logic            write_ok;
    logic [NP-1:0]   read_ok;

    for (genvar p = 0; p < NP; p++) begin : g_raddr
        assign raddr[p] = read_set_addr_in[p*AW +: AW];
    end

    // Range checks only exist when the address space is not fully populated.
    if (NUM_SET == 2**AW) begin : g_full
        assign write_ok = 1'b1;
        assign read_ok  = '1;
    end else begin : g_partial
        assign write_ok = (write_set_addr_in <= LAST_SET);
        for (genvar p = 0; p < NP; p++) begin : g_rok
            assign read_ok[p] = (raddr[p] <= LAST_SET);
        end
    end

    always_ff @(posedge clk_in) begin
        if (state == INIT) begin
            mem[sweep_ptr] <= '0;
        end else if (write_ok) begin
            for (int b = 0; b < WRITE_MASK_LEN; b++) begin
                if (write_en_in[b]) begin
                    mem[write_set_addr_in][b*BL +: BL] <= write_entry_in[b*BL +: BL];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            read_data[p] = '0;
            if (read_ok[p]) begin
                read_data[p] = mem[raddr[p]];
`ifdef LUTRAM_WRITE_FORWARD_EN
                if (state == READY && write_ok &&
                    write_set_addr_in == raddr[p]) begin
                    for (int b = 0; b < WRITE_MASK_LEN; b++) begin
                        if (write_en_in[b]) begin
                            read_data[p][b*BL +: BL] = write_entry_in[b*BL +: BL];
                        end
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state          <= INIT;
            sweep_ptr      <= '0;
            init_done_out  <= 1'b0;
            read_valid_out <= '0;
            read_entry_out <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    sweep_ptr      <= sweep_ptr + 1'b1;
                    read_valid_out <= '0;
                    if (sweep_ptr == LAST_SET) begin
                        state         <= READY;
                        init_done_out <= 1'b1;
                    end
                end
                READY: begin
                    for (int p = 0; p < NP; p++) begin
                        read_valid_out[p] <= read_en_in[p];
                        if (read_en_in[p]) begin
                            read_entry_out[p*W +: W] <= read_data[p];
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_single_write_multi_read_lutram.sv
// Directed bench for single_write_multi_read_lutram at default parameters.
// Collision expectation follows LUTRAM_WRITE_FORWARD_EN.
`timescale 1ns/1ps

module tb_single_write_multi_read_lutram;

    logic         clk;
    logic         rst;
    logic         init_done;
    logic [7:0]   wen;
    logic [5:0]   waddr;
    logic [63:0]  wdata;
    logic [1:0]   ren;
    logic [11:0]  raddr;
    logic [127:0] rdata;
    logic [1:0]   rvalid;

    int errors = 0;
    int checks = 0;

    single_write_multi_read_lutram dut (
        .clk_in            (clk),
        .reset_in          (rst),
        .init_done_out     (init_done),
        .write_en_in       (wen),
        .write_set_addr_in (waddr),
        .write_entry_in    (wdata),
        .read_en_in        (ren),
        .read_set_addr_in  (raddr),
        .read_entry_out    (rdata),
        .read_valid_out    (rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen   = '0;
        waddr = '0;
        wdata = '0;
        ren   = '0;
        raddr = '0;
    endtask

    // Release reset off-edge and count edges until init_done rises.
    task automatic release_and_sweep(input string name);
        int cyc;
        cyc = 0;
        rst = 1'b0;
        while (!init_done && cyc < 200) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc !== 64) begin
            errors++;
            $display("FAIL %s: sweep cycles=%0d expected=64", name, cyc);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #2;
        checks++;
        if (init_done !== 1'b0 || rvalid !== 2'b00 || rdata !== 128'h0) begin
            errors++;
            $display("FAIL reset_outputs: done=%b valid=%b data=%h expected 0",
                     init_done, rvalid, rdata);
        end
        step();
        step();
        #1;
        release_and_sweep("reset_sweep");
    endtask

    task automatic test_clear_all();
        int bad;
        bad = 0;
        for (int a = 0; a < 64; a++) begin
            ren   = 2'b11;
            raddr = {6'(63 - a), 6'(a)};
            step();
            checks++;
            if (rvalid !== 2'b11 || rdata !== 128'h0) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL clear_read a=%0d: valid=%b data=%h expected 11/0",
                             a, rvalid, rdata);
            end
        end
        idle();
        step();
    endtask

    task automatic test_write_full();
        wen   = 8'hFF;
        waddr = 6'd63;
        wdata = 64'hFFFFFFFF00000000;
        step();
        idle();
        ren   = 2'b01;
        raddr = {6'd0, 6'd63};
        checks++;
        if (rvalid !== 2'b00) begin
            errors++;
            $display("FAIL pre_read_valid: valid=%b expected 00", rvalid);
        end
        step();
        checks++;
        if (rvalid !== 2'b01 || rdata[63:0] !== 64'hFFFFFFFF00000000) begin
            errors++;
            $display("FAIL write_full: valid=%b data=%h expected 01/ffffffff00000000",
                     rvalid, rdata[63:0]);
        end
        idle();
        step();
    endtask

    task automatic test_mask();
        wen   = 8'h00;
        waddr = 6'd63;
        wdata = 64'h00000000FFFFFFFF;
        step();
        idle();
        ren   = 2'b01;
        raddr = {6'd0, 6'd63};
        step();
        checks++;
        if (rdata[63:0] !== 64'hFFFFFFFF00000000) begin
            errors++;
            $display("FAIL mask_zero: data=%h expected ffffffff00000000", rdata[63:0]);
        end
        idle();
        wen   = 8'h0F;
        waddr = 6'd63;
        wdata = 64'h00000000FFFFFFFF;
        step();
        idle();
        ren   = 2'b01;
        raddr = {6'd0, 6'd63};
        step();
        checks++;
        if (rdata[63:0] !== 64'hFFFFFFFFFFFFFFFF) begin
            errors++;
            $display("FAIL mask_low: data=%h expected ffffffffffffffff", rdata[63:0]);
        end
        idle();
        step();
    endtask

    task automatic test_collision();
        logic [63:0] exp;
`ifdef LUTRAM_WRITE_FORWARD_EN
        exp = 64'h0000000000007788;
`else
        exp = 64'h0;
`endif
        wen   = 8'h03;
        waddr = 6'd5;
        wdata = 64'h1122334455667788;
        ren   = 2'b10;
        raddr = {6'd5, 6'd0};
        step();
        checks++;
        if (rvalid !== 2'b10 || rdata[127:64] !== exp) begin
            errors++;
            $display("FAIL collision: valid=%b data=%h expected 10/%h",
                     rvalid, rdata[127:64], exp);
        end
        idle();
        ren   = 2'b10;
        raddr = {6'd5, 6'd0};
        step();
        checks++;
        if (rdata[127:64] !== 64'h0000000000007788) begin
            errors++;
            $display("FAIL after_collision: data=%h expected 7788", rdata[127:64]);
        end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] pat;
        pat   = 2'b11;
        raddr = {6'd63, 6'd63};
        for (int i = 0; i < 3; i++) begin
            ren = (i == 1) ? 2'b00 : 2'b11;
            step();
            checks++;
            if (rvalid !== ren ||
                rdata !== {64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF}) begin
                errors++;
                $display("FAIL toggle i=%0d: valid=%b data=%h expected %b/all ones",
                         i, rvalid, rdata, ren);
            end
        end
        idle();
        // A read of a different address on one port must not disturb the other.
        ren   = 2'b10;
        raddr = {6'd5, 6'd63};
        step();
        checks++;
        if (rvalid !== 2'b10 || rdata[63:0] !== 64'hFFFFFFFFFFFFFFFF ||
            rdata[127:64] !== 64'h7788) begin
            errors++;
            $display("FAIL port_indep: valid=%b data=%h", rvalid, rdata);
        end
        idle();
        step();
        checks++;
        if (rvalid !== 2'b00 || rdata[127:64] !== 64'h7788) begin
            errors++;
            $display("FAIL hold_idle: valid=%b data=%h", rvalid, rdata);
        end
    endtask

    task automatic test_reset_mid();
        ren   = 2'b11;
        raddr = {6'd63, 6'd63};
        wen   = 8'hFF;
        waddr = 6'd10;
        wdata = 64'hDEADBEEFCAFEF00D;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (init_done !== 1'b0 || rvalid !== 2'b00 || rdata !== 128'h0) begin
            errors++;
            $display("FAIL reset_traffic: done=%b valid=%b data=%h expected 0",
                     init_done, rvalid, rdata);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (rvalid !== 2'b00 || init_done !== 1'b0) begin
                errors++;
                $display("FAIL init_read i=%0d: valid=%b done=%b expected 00/0",
                         i, rvalid, init_done);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (init_done !== 1'b0 || rvalid !== 2'b00 || rdata !== 128'h0) begin
            errors++;
            $display("FAIL reset_sweep30: done=%b valid=%b data=%h expected 0",
                     init_done, rvalid, rdata);
        end
        idle();
        step();
        #1;
        release_and_sweep("resweep");
        ren   = 2'b11;
        raddr = {6'd5, 6'd63};
        step();
        checks++;
        if (rvalid !== 2'b11 || rdata !== 128'h0) begin
            errors++;
            $display("FAIL cleared_after_reset: valid=%b data=%h expected 11/0",
                     rvalid, rdata);
        end
        ren   = 2'b01;
        raddr = {6'd0, 6'd10};
        step();
        checks++;
        if (rdata[63:0] !== 64'h0) begin
            errors++;
            $display("FAIL aborted_write: data=%h expected 0", rdata[63:0]);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_clear_all();
        test_write_full();
        test_mask();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
